// File: rtl/sd_110_stream_ctrl.sv
// Word serializer feeding a "110" sequence detector: accepts one 8-bit word in IDLE,
// shifts it out MSB first over eight SHIFT cycles, then pulses word_done in DONE.
module sd_110_stream_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clr_cnt,
    output logic       out,
    output logic       det_pulse,
    output logic [7:0] det_count,
    output logic       busy,
    output logic       word_done,
    output logic [1:0] dbg_state,
    output logic [1:0] dbg_det_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] DET_S0 = 2'd0;
    localparam logic [1:0] DET_S1 = 2'd1;
    localparam logic [1:0] DET_S2 = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] det_q, det_d;
    logic       out_q, out_d;
    logic       pulse_q, pulse_d;
    logic [7:0] count_q, count_d;
    logic       detect;
    logic       bit_in;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready is high only in IDLE, so in_valid/in_data are ignored everywhere else.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        det_d   = det_q;
        detect  = 1'b0;
        bit_in  = shreg_q[7];

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = 3'd7;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[6:0], 1'b0};
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end
                // The detector only moves while a bit is being presented.
                case (det_q)
                    DET_S0: det_d = bit_in ? DET_S1 : DET_S0;
                    DET_S1: det_d = bit_in ? DET_S2 : DET_S0;
                    DET_S2: begin
                        if (bit_in) begin
                            det_d = DET_S2;
                        end else begin
                            det_d  = DET_S0;
                            detect = 1'b1;
                        end
                    end
                    default: det_d = DET_S0;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        pulse_d = detect;
        out_d   = out_q ^ detect;

        // Clear beats a same-cycle increment; the count sticks at 255.
        count_d = count_q;
        if (clr_cnt) begin
            count_d = 8'd0;
        end else if (detect && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= 8'd0;
            cnt_q   <= 3'd0;
            det_q   <= DET_S0;
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            out_q   <= out_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign word_done     = (state_q == ST_DONE);
    assign out           = out_q;
    assign det_pulse     = pulse_q;
    assign det_count     = count_q;
    assign dbg_state     = state_q;
    assign dbg_det_state = det_q;

endmodule

// File: tb/tb_sd_110_stream_ctrl.sv
// Directed bench for sd_110_stream_ctrl: hand-computed per-cycle masks for pulses,
// word_done, out and in_ready, plus saturation, clear-collision and mid-word reset cases.
module tb_sd_110_stream_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clr_cnt;
    logic       out;
    logic       det_pulse;
    logic [7:0] det_count;
    logic       busy;
    logic       word_done;
    logic [1:0] dbg_state;
    logic [1:0] dbg_det_state;

    int n_checks;
    int n_pass;

    sd_110_stream_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clr_cnt      (clr_cnt),
        .out          (out),
        .det_pulse    (det_pulse),
        .det_count    (det_count),
        .busy         (busy),
        .word_done    (word_done),
        .dbg_state    (dbg_state),
        .dbg_det_state(dbg_det_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_cnt  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge while IDLE; mask bit k is the value seen in cycle t+1+k.
    task automatic send_word(input logic [7:0] d, output logic [9:0] pm,
                             output logic [9:0] wm, output logic [9:0] om,
                             output logic [9:0] rm);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int k = 0; k < 10; k++) begin
            pm[k] = det_pulse;
            wm[k] = word_done;
            om[k] = out;
            rm[k] = in_ready;
            if (k < 9) @(negedge clk);
        end
    endtask

    logic [9:0]  pm, wm, om, rm;
    logic [20:0] rmask;
    int          acc, npulse, wd_seen;
    logic        out_before;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_cnt  = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out", out, 0);
        check("rst_det_pulse", det_pulse, 0);
        check("rst_det_count", det_count, 0);
        check("rst_word_done", word_done, 0);

        // 1101_1000: detects in t+3 and t+6 -> pulses in t+4 and t+7
        send_word(8'hD8, pm, wm, om, rm);
        check("d8_pulses", pm, 10'b0001001000);
        check("d8_word_done", wm, 10'b0100000000);
        check("d8_out", om, 10'b0000111000);
        check("d8_ready", rm, 10'b1000000000);
        check("d8_count", det_count, 2);
        check("d8_out_end", out, 0);

        // 0000_0011 then 0000_0000: pattern spans the word boundary
        do_reset();
        send_word(8'h03, pm, wm, om, rm);
        check("w03_pulses", pm, 10'b0000000000);
        send_word(8'h00, pm, wm, om, rm);
        check("w00_pulses", pm, 10'b0000000010);
        check("span_count", det_count, 1);
        check("span_out", out, 1);

        // in_valid held high with changing data: only cycles t, t+10, t+20 accept
        do_reset();
        acc    = 0;
        npulse = 0;
        for (int k = 0; k < 21; k++) begin
            in_valid = 1'b1;
            in_data  = ((k % 10) == 0) ? 8'h00 : 8'hD8;
            rmask[k] = in_ready;
            if (in_ready) acc++;
            if (det_pulse) npulse++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (det_pulse) npulse++;
            @(negedge clk);
        end
        check("hold_ready_mask", rmask, 21'h100401);
        check("hold_accepts", acc, 3);
        check("hold_pulses", npulse, 0);
        check("hold_count", det_count, 0);

        // Drive det_count to saturation with D8 words (two detects each)
        do_reset();
        for (int w = 0; w < 127; w++) send_word(8'hD8, pm, wm, om, rm);
        check("sat_count_254", det_count, 254);
        send_word(8'hD8, pm, wm, om, rm);
        check("sat_count_255", det_count, 255);
        send_word(8'hD8, pm, wm, om, rm);
        check("sat_pulses", pm, 10'b0001001000);
        check("sat_out", om, 10'b0000111000);
        check("sat_count_hold", det_count, 255);

        // clr_cnt in the same cycle as the first detect (t+3)
        out_before = out;
        in_valid   = 1'b1;
        in_data    = 8'hD8;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_count", det_count, 0);
        check("clr_pulse", det_pulse, 1);
        check("clr_out", out, {31'd0, ~out_before});
        repeat (6) @(negedge clk);
        check("clr_count_after", det_count, 1);
        check("clr_out_after", out, {31'd0, out_before});
        check("clr_idle", in_ready, 1);

        // Set out=1 and count=2, then reset in the 4th SHIFT cycle of 1111_0110
        send_word(8'h06, pm, wm, om, rm);
        check("w06_pulses", pm, 10'b0100000000);
        check("w06_out", out, 1);
        check("w06_count", det_count, 2);
        in_valid = 1'b1;
        in_data  = 8'hF6;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_out", out, 0);
        check("mid_rst_count", det_count, 0);
        check("mid_rst_pulse", det_pulse, 0);
        wd_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (word_done) wd_seen++;
            @(negedge clk);
        end
        check("mid_rst_no_done", wd_seen, 0);
        send_word(8'h40, pm, wm, om, rm);
        check("post_rst_pulses", pm, 10'b0000000000);
        check("post_rst_count", det_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
